ext_out_channel: RTL and testbench

//   Buffered controller for the EXT output resource. It accepts bytes from the write-back

---
 rtl/ext_out_channel.sv | 123 ++++++++++++
 tb/tb_ext_out_channel.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_out_channel.sv
// Buffered EXT output channel: write-back bytes are queued in a small FIFO and
// drained to an external sink over a four-phase xreq/xack handshake.
module ext_out_channel #(
  parameter int D_WIDTH    = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [D_WIDTH-1:0]    cq,
  input  logic                  cwre,
  output logic                  cbsy,
  output logic [D_WIDTH-1:0]    xq,
  output logic                  xreq,
  input  logic                  xack,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [D_WIDTH-1:0]    mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [1:0]            state_r;
  logic [1:0]            state_nx_s;
  logic [D_WIDTH-1:0]    xq_r;
  logic                  xreq_r;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;

  // Full flag comes from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    full_s = (count_r == FULL_COUNT);
    push_s = cwre && !full_s;
    pop_s  = (state_r == ST_IDLE) && (count_r != '0);
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= cq;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sink handshake next-state; xack seen in IDLE is deliberately ignored.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != '0) begin
          state_nx_s = ST_REQ;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (xack) begin
          state_nx_s = ST_RELEASE;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (!xack) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RELEASE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Registered sink outputs; xq is only reloaded when the head is popped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      xq_r    <= '0;
      xreq_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (pop_s) begin
        xq_r <= mem_r[rd_ptr_r];
      end
      xreq_r <= (state_nx_s == ST_REQ);
    end
  end

  assign cbsy  = full_s;
  assign xq    = xq_r;
  assign xreq  = xreq_r;
  assign count = count_r;

endmodule

// File: tb/tb_ext_out_channel.sv
// Directed self-checking bench for ext_out_channel (FIFO + four-phase sink).
module tb_ext_out_channel;

  logic       clk;
  logic       reset;
  logic [7:0] cq;
  logic       cwre;
  logic       cbsy;
  logic [7:0] xq;
  logic       xreq;
  logic       xack;
  logic [3:0] count;

  int checks;
  int errors;

  ext_out_channel #(.D_WIDTH(8), .DEPTH_LOG2(3)) dut (
    .clk   (clk),
    .reset (reset),
    .cq    (cq),
    .cwre  (cwre),
    .cbsy  (cbsy),
    .xq    (xq),
    .xreq  (xreq),
    .xack  (xack),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete one handshake for the byte expected on xq.
  task automatic sink_one(input logic [7:0] exp_byte);
    int n;
    n = 0;
    while (!xreq && n < 32) begin
      tick();
      n++;
    end
    check_val("wait_xreq", {31'd0, xreq}, 32'd1);
    check_val("drain_byte", {24'd0, xq}, {24'd0, exp_byte});
    xack = 1'b1;
    tick();
    check_val("xreq_fall", {31'd0, xreq}, 32'd0);
    xack = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] tx_next;
    logic [7:0] rx_next;
    logic       accepted;
    checks = 0;
    errors = 0;

    // 1. reset with active write strobe
    reset = 1'b1;
    cwre  = 1'b1;
    cq    = 8'hFF;
    xack  = 1'b0;
    tick();
    tick();
    check_val("rst_count", {28'd0, count}, 32'd0);
    check_val("rst_xreq", {31'd0, xreq}, 32'd0);
    check_val("rst_xq", {24'd0, xq}, 32'd0);
    check_val("rst_cbsy", {31'd0, cbsy}, 32'd0);
    reset = 1'b0;
    cwre  = 1'b0;
    tick();
    check_val("post_rst_count", {28'd0, count}, 32'd0);

    // 2. single byte latency and handshake
    cq   = 8'h41;
    cwre = 1'b1;
    tick();
    cwre = 1'b0;
    check_val("t2_count_push", {28'd0, count}, 32'd1);
    check_val("t2_xreq_early", {31'd0, xreq}, 32'd0);
    tick();
    check_val("t2_xreq", {31'd0, xreq}, 32'd1);
    check_val("t2_xq", {24'd0, xq}, 32'h41);
    check_val("t2_count_pop", {28'd0, count}, 32'd0);
    xack = 1'b1;
    tick();
    check_val("t2_xreq_fall", {31'd0, xreq}, 32'd0);
    xack = 1'b0;
    tick();
    tick();
    check_val("t2_idle_xreq", {31'd0, xreq}, 32'd0);
    check_val("t2_idle_count", {28'd0, count}, 32'd0);

    // 3. fill to full while the sink stalls; the tenth byte is dropped
    for (int i = 0; i < 10; i++) begin
      cq   = 8'(i);
      cwre = 1'b1;
      tick();
    end
    cwre = 1'b0;
    check_val("t3_count_full", {28'd0, count}, 32'd8);
    check_val("t3_cbsy", {31'd0, cbsy}, 32'd1);
    check_val("t3_xq_first", {24'd0, xq}, 32'h00);
    for (int i = 0; i < 9; i++) begin
      sink_one(8'(i));
    end
    tick();
    tick();
    check_val("t3_no_09_xreq", {31'd0, xreq}, 32'd0);
    check_val("t3_empty", {28'd0, count}, 32'd0);
    check_val("t3_cbsy_clr", {31'd0, cbsy}, 32'd0);

    // 4. pop while full with cwre held: push only lands the following cycle
    for (int i = 0; i < 9; i++) begin
      cq   = 8'h30 + 8'(i);
      cwre = 1'b1;
      tick();
    end
    check_val("t4_full", {28'd0, count}, 32'd8);
    cq   = 8'h39;
    xack = 1'b1;
    tick();
    xack = 1'b0;
    check_val("t4_rel_count", {28'd0, count}, 32'd8);
    tick();
    check_val("t4_idle_count", {28'd0, count}, 32'd8);
    tick();
    check_val("t4_pop_count", {28'd0, count}, 32'd7);
    check_val("t4_pop_xq", {24'd0, xq}, 32'h31);
    tick();
    cwre = 1'b0;
    check_val("t4_refill", {28'd0, count}, 32'd8);
    for (int i = 1; i < 10; i++) begin
      sink_one(8'h30 + 8'(i));
    end
    tick();
    check_val("t4_empty", {28'd0, count}, 32'd0);

    // 5. push/pop in the same IDLE cycle, then stream 0x10..0x23 across pointer wrap
    for (int i = 0; i < 4; i++) begin
      cq   = 8'h10 + 8'(i);
      cwre = 1'b1;
      tick();
    end
    cwre = 1'b0;
    check_val("t5_count3", {28'd0, count}, 32'd3);
    check_val("t5_xq10", {24'd0, xq}, 32'h10);
    xack = 1'b1;
    tick();
    xack = 1'b0;
    tick();
    cq   = 8'h14;
    cwre = 1'b1;
    tick();
    check_val("t5_pushpop_count", {28'd0, count}, 32'd3);
    check_val("t5_xq11", {24'd0, xq}, 32'h11);
    tx_next = 8'h15;
    rx_next = 8'h11;
    for (int cyc = 0; cyc < 400 && rx_next <= 8'h23; cyc++) begin
      if (xreq && !xack) begin
        check_val("t5_order", {24'd0, xq}, {24'd0, rx_next});
        rx_next = rx_next + 8'd1;
        xack = 1'b1;
      end else if (!xreq && xack) begin
        xack = 1'b0;
      end else begin
        xack = xack;
      end
      cwre = (tx_next <= 8'h23);
      cq   = tx_next;
      accepted = cwre && !cbsy;
      tick();
      if (accepted) begin
        tx_next = tx_next + 8'd1;
      end
    end
    cwre = 1'b0;
    xack = 1'b0;
    check_val("t5_all_rx", {24'd0, rx_next}, 32'h24);
    tick();
    tick();
    check_val("t5_empty", {28'd0, count}, 32'd0);

    // 6. asynchronous reset mid-handshake with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      cq   = 8'h60 + 8'(i);
      cwre = 1'b1;
      tick();
    end
    cwre = 1'b0;
    check_val("t6_pre_xreq", {31'd0, xreq}, 32'd1);
    check_val("t6_pre_count", {28'd0, count}, 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_async_xreq", {31'd0, xreq}, 32'd0);
    check_val("t6_async_count", {28'd0, count}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    cq   = 8'h55;
    cwre = 1'b1;
    tick();
    cwre = 1'b0;
    tick();
    check_val("t6_next_xreq", {31'd0, xreq}, 32'd1);
    check_val("t6_next_xq", {24'd0, xq}, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
